lda_line_engine: RTL

Bresenham line-drawing engine, directly upstream of the VGA adapter in the LDA hardware interface.
- Accepts one line command (endpoints plus colour) through a start handshake.
- Emits one pixel write per accepted cycle to the frame-buffer/VGA adapter write port, with valid/ready backpressure.
- Reports busy/done back to the Avalon-MM register front end, so the Nios II software can poll completion.

---
 rtl/lda_pkg.sv | 26 ++
 rtl/lda_setup.sv | 56 +++++
 rtl/lda_line_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lda_pkg.sv
// Shared types and widths for the LDA Bresenham line engine.
// Consumed by lda_setup and lda_line_engine (optional clipping: LDA_CLIP_EN).
package lda_pkg;

    localparam int LDA_X_W     = 9;
    localparam int LDA_Y_W     = 8;
    localparam int LDA_COLOR_W = 3;
    localparam int LDA_C_W     = (LDA_X_W > LDA_Y_W) ? LDA_X_W : LDA_Y_W;
    localparam int LDA_ERR_W   = LDA_C_W + 2;

    typedef logic [LDA_C_W-1:0]            coord_t;
    typedef logic [LDA_COLOR_W-1:0]        color_t;
    typedef logic signed [LDA_ERR_W-1:0]   err_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } lda_state_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lda_setup.sv
// Combinational Bresenham setup: octant folding, endpoint ordering and initial error.
// Kept standalone so the software-model checker can reuse the same INIT math.
module lda_setup
    import lda_pkg::*;
#(
    parameter int C_W   = LDA_C_W,
    parameter int ERR_W = C_W + 2
) (
    input  logic [C_W-1:0]          x0,
    input  logic [C_W-1:0]          y0,
    input  logic [C_W-1:0]          x1,
    input  logic [C_W-1:0]          y1,
    output logic                    steep,
    output logic [C_W-1:0]          xs,
    output logic [C_W-1:0]          ys,
    output logic [C_W-1:0]          xe,
    output logic [C_W-1:0]          dx,
    output logic [C_W-1:0]          dy,
    output logic                    ystep_up,
    output logic signed [ERR_W-1:0] err_init
);

    logic [C_W-1:0] adx, ady;
    logic [C_W-1:0] ax0, ay0, ax1, ay1;
    logic [C_W-1:0] ye;

    // Fold the line into the shallow octant, then order it along the primary axis
    always_comb begin
        adx   = (x1 >= x0) ? x1 - x0 : x0 - x1;
        ady   = (y1 >= y0) ? y1 - y0 : y0 - y1;
        steep = ady > adx;

        ax0 = steep ? y0 : x0;
        ay0 = steep ? x0 : y0;
        ax1 = steep ? y1 : x1;
        ay1 = steep ? x1 : y1;

        if (ax0 > ax1) begin
            xs = ax1;
            ys = ay1;
            xe = ax0;
            ye = ay0;
        end else begin
            xs = ax0;
            ys = ay0;
            xe = ax1;
            ye = ay1;
        end

        dx       = xe - xs;
        dy       = (ye >= ys) ? ye - ys : ys - ye;
        ystep_up = ys < ye;
        err_init = -$signed({2'b00, dx >> 1});
    end

endmodule

// File: rtl/lda_line_engine.sv
// Bresenham line engine feeding the VGA adapter write port with valid/ready.
// Define LDA_CLIP_EN to suppress off-screen points instead of emitting them.
module lda_line_engine
    import lda_pkg::*;
#(
    parameter int X_W      = LDA_X_W,
    parameter int Y_W      = LDA_Y_W,
    parameter int COLOR_W  = LDA_COLOR_W,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     plot_x,
    output logic [Y_W-1:0]     plot_y,
    output logic [COLOR_W-1:0] plot_color,
    output logic               plot_valid,
    input  logic               plot_ready
);

    localparam int C_W   = max_w(X_W, Y_W);
    localparam int ERR_W = C_W + 2;

    lda_state_e state, state_next;

    logic [X_W-1:0]     x0_r, x1_r;
    logic [Y_W-1:0]     y0_r, y1_r;
    logic [COLOR_W-1:0] color_r;

    logic                    steep_r, ystep_up_r;
    logic [C_W-1:0]          x_r, y_r, xe_r, dx_r, dy_r;
    logic signed [ERR_W-1:0] err_r, err_sum;

    logic                    s_steep, s_ystep_up;
    logic [C_W-1:0]          s_xs, s_ys, s_xe, s_dx, s_dy;
    logic signed [ERR_W-1:0] s_err;

    logic [C_W-1:0] pos_x, pos_y;
    logic           off_screen, advance, last_point;

    lda_setup #(.C_W(C_W), .ERR_W(ERR_W)) u_setup (
        .x0       (C_W'(x0_r)),
        .y0       (C_W'(y0_r)),
        .x1       (C_W'(x1_r)),
        .y1       (C_W'(y1_r)),
        .steep    (s_steep),
        .xs       (s_xs),
        .ys       (s_ys),
        .xe       (s_xe),
        .dx       (s_dx),
        .dy       (s_dy),
        .ystep_up (s_ystep_up),
        .err_init (s_err)
    );

    assign pos_x = steep_r ? y_r : x_r;
    assign pos_y = steep_r ? x_r : y_r;

`ifdef LDA_CLIP_EN
    assign off_screen = (int'(pos_x) >= SCREEN_W) || (int'(pos_y) >= SCREEN_H);
`else
    logic unused_screen;
    assign off_screen    = 1'b0;
    assign unused_screen = ^{pos_x, pos_y, SCREEN_W[0], SCREEN_H[0]};
`endif

    assign plot_x     = pos_x[X_W-1:0];
    assign plot_y     = pos_y[Y_W-1:0];
    assign plot_color = color_r;
    assign plot_valid = (state == DRAW) && !off_screen;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // Clipped points step on their own; visible points wait for the adapter
    assign advance    = (state == DRAW) && (off_screen || plot_ready);
    assign last_point = (x_r == xe_r);
    assign err_sum    = err_r + $signed({2'b00, dy_r});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = DRAW;
            DRAW:    if (advance && last_point) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_r       <= '0;
            y0_r       <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
            color_r    <= '0;
            steep_r    <= 1'b0;
            ystep_up_r <= 1'b0;
            x_r        <= '0;
            y_r        <= '0;
            xe_r       <= '0;
            dx_r       <= '0;
            dy_r       <= '0;
            err_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x0_r    <= x0;
                        y0_r    <= y0;
                        x1_r    <= x1;
                        y1_r    <= y1;
                        color_r <= color;
                    end
                end
                INIT: begin
                    steep_r    <= s_steep;
                    ystep_up_r <= s_ystep_up;
                    x_r        <= s_xs;
                    y_r        <= s_ys;
                    xe_r       <= s_xe;
                    dx_r       <= s_dx;
                    dy_r       <= s_dy;
                    err_r      <= s_err;
                end
                DRAW: begin
                    // Minor-axis step once the accumulated error goes positive
                    if (advance && !last_point) begin
                        x_r <= x_r + C_W'(1);
                        if (!err_sum[ERR_W-1] && (err_sum != '0)) begin
                            y_r   <= ystep_up_r ? y_r + C_W'(1) : y_r - C_W'(1);
                            err_r <= err_sum - $signed({2'b00, dx_r});
                        end else begin
                            err_r <= err_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
